onehot_pulse_decoder: RTL and testbench
=======================================

# onehot_pulse_decoder

Registered 2-to-4 decoder and the receiving end of the 4-input priority encoder's {A, V} output. It accepts an encoded index A with its valid flag V through a req/ready handshake. It then drives the matching one-hot line Y[A] high for a programmable number of cycles, followed by a programmable idle gap. It sits between the request encoder and the four downstream strobe consumers.

## Interface
- PULSE_LEN, 4: cycles Y is held one-hot per accepted request; legal range 1..255.
- GAP_LEN, 1: idle cycles after each pulse before the next request is accepted; legal range 0..255.
- CNT_W, 8: width of the invalid-request counter.
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- A  input  2  encoded index from the priority encoder.
- V  input  1  valid flag paired with A; V=0 means no input was active.
- req  input  1  request strobe; sampled only when ready=1.
- ready  output  1  high when a request can be accepted (IDLE state).
- Y  output  4  one-hot decoded strobe, registered.
- busy  output  1  high in PULSE and GAP states.
- done  output  1  one-cycle pulse in the first cycle after Y drops.
- err_cnt  output  CNT_W  saturating count of requests with V=0 (see Configuration).

## Operation
- State machine states: IDLE, PULSE, GAP.
- Reset values (asynchronous, applied immediately on rst_n low): state=IDLE, Y=4'b0000, ready=1, busy=0, done=0, err_cnt=0, internal counters=0.
- IDLE:
  - ready=1, Y=0.
  - On an edge with req=1 and V=1: latch A, load the counter with PULSE_LEN-1, go to PULSE.
  - On an edge with req=1 and V=0: stay in IDLE, produce no pulse, increment err_cnt.
- PULSE:
  - Y = 1<<A_latched, busy=1, ready=0.
  - The counter decrements each cycle.
  - At count 0: if GAP_LEN>0, go to GAP and load the counter with GAP_LEN-1; otherwise go to IDLE.
- GAP:
  - Y=0, busy=1, ready=0.
  - At count 0, go to IDLE.
- done: asserted for exactly one cycle, namely the first cycle in which Y returns to 0 after a pulse. This holds regardless of GAP_LEN.
- req while ready=0: ignored entirely. It is not queued and not counted.
- A and V are sampled only on the accepting edge. Changes to A during PULSE do not affect Y.
- Y is never multi-hot. Y is never nonzero outside PULSE.
- err_cnt saturates at 2^CNT_W-1 and does not wrap.

## Timing
- Cycle k denotes the interval after rising edge k. The request is accepted on edge 0.
- Cycles 1..PULSE_LEN: Y one-hot, busy=1, ready=0. Latency from the accept edge to Y valid is 1 cycle.
- Cycle PULSE_LEN+1: Y=0, done=1.
  - GAP_LEN=0: ready=1 in this cycle, so the next accept can happen at edge PULSE_LEN+1.
  - GAP_LEN>0: cycles PULSE_LEN+1..PULSE_LEN+GAP_LEN are in GAP with ready=0. ready=1 in cycle PULSE_LEN+GAP_LEN+1.
- Minimum spacing between accept edges: PULSE_LEN+GAP_LEN+1.
- err_cnt updates one cycle after the rejecting edge.
- Reset asserted mid-PULSE or mid-GAP: Y clears asynchronously with no done pulse. After rst_n deasserts, the first accept is possible on the first rising edge.

## Configuration
- ONEHOT_PULSE_DECODER_ERRCNT_EN defined: the err_cnt register and its saturating increment are compiled in, and behave as described above.
- Not defined: no counter logic is built. err_cnt is tied to constant 0 and the port remains for interface stability. Requests with V=0 are still ignored.

## Test plan
- Reset, then req=1, V=1, A=2 for one edge (PULSE_LEN=4, GAP_LEN=1). Required: Y=4'b0100 in cycles 1..4; Y=0 and done=1 in cycle 5; ready=0 in cycle 5; ready=1 in cycle 6.
- Sweep A=0..3 back-to-back with req held high. Required: the Y sequence is 0001, 0010, 0100, 1000, with accepts exactly PULSE_LEN+GAP_LEN+1 edges apart and each pulse 4 cycles wide.
- req=1 with V=0, repeated 3 times in IDLE (macro defined). Required: Y stays 0, ready stays 1, err_cnt=3. With the macro undefined, err_cnt=0.
- During PULSE, change A to 3 and pulse req. Required: Y is unchanged and the extra req is not queued; after GAP, ready=1 and Y=0.
- Pull rst_n low in cycle 2 of a pulse. Required: Y=0 immediately with no done pulse. After release, req=1, V=1, A=1 gives Y=0010 in the next cycle.
- CNT_W=2 with 5 V=0 requests. Required: err_cnt saturates at 3.

Source files
------------

// File: rtl/onehot_pulse_decoder.sv
// onehot_pulse_decoder
//   Registered 2-to-4 decoder fed by a priority encoder's {A, V} pair.
//   An accepted request (req=1, V=1 while ready=1) drives Y[A] high for
//   PULSE_LEN cycles, then holds an idle gap of GAP_LEN cycles before the
//   next request can be taken. done pulses in the first cycle after Y drops.
//
//   Optional feature macro: ONEHOT_PULSE_DECODER_ERRCNT_EN
//     defined     -> err_cnt is a saturating count of requests taken with V=0
//     not defined -> err_cnt is tied to zero, no counter logic is built
//
//   Legal parameter ranges: PULSE_LEN 1..255, GAP_LEN 0..255, CNT_W >= 1.

module onehot_pulse_decoder #(
    parameter int PULSE_LEN = 4,
    parameter int GAP_LEN   = 1,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       A,
    input  logic             V,
    input  logic             req,
    output logic             ready,
    output logic [3:0]       Y,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] err_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_PULSE = 2'b01,
        ST_GAP   = 2'b10
    } state_t;

    // Counter reload values. The gap reload is only meaningful when a gap
    // exists; with GAP_LEN=0 the GAP state is never entered.
    localparam logic [7:0] PULSE_LOAD = 8'(PULSE_LEN - 1);
    localparam bit         GAP_EN     = (GAP_LEN > 0);
    localparam logic [7:0] GAP_LOAD   = GAP_EN ? 8'(GAP_LEN - 1) : 8'd0;

    // Map an encoded index to its one-hot strobe; never produces multi-hot.
    function automatic logic [3:0] decode_idx(input logic [1:0] idx);
        logic [3:0] res;
        case (idx)
            2'd0:    res = 4'b0001;
            2'd1:    res = 4'b0010;
            2'd2:    res = 4'b0100;
            2'd3:    res = 4'b1000;
            default: res = 4'b0000;
        endcase
        return res;
    endfunction

    state_t     state_q, state_d;
    logic [7:0] cnt_q,   cnt_d;
    logic [3:0] y_q,     y_d;
    logic       ready_q, ready_d;
    logic       busy_q,  busy_d;
    logic       done_q,  done_d;
    logic       accept_s;
    logic       reject_s;

    // A request is only looked at in IDLE; anything arriving while busy is dropped.
    assign accept_s = (state_q == ST_IDLE) && req && V;
    assign reject_s = (state_q == ST_IDLE) && req && !V;

    // Next-state and next-output computation for the pulse/gap sequencer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        y_d     = y_q;
        ready_d = ready_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                y_d     = 4'b0000;
                ready_d = 1'b1;
                busy_d  = 1'b0;
                if (accept_s) begin
                    state_d = ST_PULSE;
                    cnt_d   = PULSE_LOAD;
                    y_d     = decode_idx(A);
                    ready_d = 1'b0;
                    busy_d  = 1'b1;
                end else begin
                    cnt_d   = 8'd0;
                end
            end
            ST_PULSE: begin
                if (cnt_q == 8'd0) begin
                    // Y drops on this edge, so done marks the following cycle
                    // whether or not a gap follows.
                    y_d    = 4'b0000;
                    done_d = 1'b1;
                    if (GAP_EN) begin
                        state_d = ST_GAP;
                        cnt_d   = GAP_LOAD;
                        ready_d = 1'b0;
                        busy_d  = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        cnt_d   = 8'd0;
                        ready_d = 1'b1;
                        busy_d  = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_GAP: begin
                y_d = 4'b0000;
                if (cnt_q == 8'd0) begin
                    state_d = ST_IDLE;
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                // Unreachable encoding: recover to a clean IDLE.
                state_d = ST_IDLE;
                cnt_d   = 8'd0;
                y_d     = 4'b0000;
                ready_d = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Sequencer state and registered outputs, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
            y_q     <= 4'b0000;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign ready = ready_q;
    assign Y     = y_q;
    assign busy  = busy_q;
    assign done  = done_q;

`ifdef ONEHOT_PULSE_DECODER_ERRCNT_EN
    // Saturating increment: holds at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
        logic [CNT_W-1:0] res;
        if (&val) begin
            res = val;
        end else begin
            res = val + CNT_W'(1);
        end
        return res;
    endfunction

    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    // Count requests seen in IDLE with V=0.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (reject_s) begin
            err_cnt_d = sat_inc(err_cnt_q);
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end

    // Invalid-request counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    // Port kept for interface stability; V=0 requests are simply dropped.
    logic unused_reject_s;
    assign unused_reject_s = reject_s;
    assign err_cnt         = '0;
`endif

endmodule

// File: tb/tb_onehot_pulse_decoder.sv
// Directed self-checking bench for onehot_pulse_decoder.
// dut : PULSE_LEN=4, GAP_LEN=1, CNT_W=8
// dut2: PULSE_LEN=2, GAP_LEN=0, CNT_W=2 (saturation and no-gap timing)
`timescale 1ns/1ps

module tb_onehot_pulse_decoder;

`ifdef ONEHOT_PULSE_DECODER_ERRCNT_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] A = 2'd0;
    logic       V = 1'b0;
    logic       req = 1'b0;
    logic       req2 = 1'b0;

    logic       ready, busy, done;
    logic [3:0] Y;
    logic [7:0] err_cnt;
    logic       ready2, busy2, done2;
    logic [3:0] Y2;
    logic [1:0] err_cnt2;

    int n_checks = 0;
    int n_fail   = 0;

    onehot_pulse_decoder #(.PULSE_LEN(4), .GAP_LEN(1), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .A(A), .V(V), .req(req),
        .ready(ready), .Y(Y), .busy(busy), .done(done), .err_cnt(err_cnt)
    );

    onehot_pulse_decoder #(.PULSE_LEN(2), .GAP_LEN(0), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .A(A), .V(V), .req(req2),
        .ready(ready2), .Y(Y2), .busy(busy2), .done(done2), .err_cnt(err_cnt2)
    );

    always #5 clk = ~clk;

    // One rising edge, then land on the falling edge to sample and drive.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        n_checks++;
        if ({Y, ready, busy, done} !== {4'b0000, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_outputs: Y/ready/busy/done got %b %b %b %b want 0000 1 0 0", Y, ready, busy, done);
        end
        n_checks++;
        if (err_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_err_cnt: got %0d want 0", err_cnt);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_pulse();
        A = 2'd2; V = 1'b1; req = 1'b1;
        tick();                 // edge 0 accepts, now in cycle 1
        req = 1'b0; V = 1'b0; A = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            n_checks++;
            if ({Y, ready, busy, done} !== {4'b0100, 1'b0, 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL single_pulse_c%0d: Y/ready/busy/done got %b %b %b %b want 0100 0 1 0", k, Y, ready, busy, done);
            end
            tick();
        end
        n_checks++;             // cycle 5: gap cycle with done
        if ({Y, ready, busy, done} !== {4'b0000, 1'b0, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL single_pulse_c5: Y/ready/busy/done got %b %b %b %b want 0000 0 1 1", Y, ready, busy, done);
        end
        tick();
        n_checks++;             // cycle 6: back to idle
        if ({Y, ready, busy, done} !== {4'b0000, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL single_pulse_c6: Y/ready/busy/done got %b %b %b %b want 0000 1 0 0", Y, ready, busy, done);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] one;
        logic [3:0] exp_y;
        one = 4'b0001;
        V = 1'b1; req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            A = 2'(i);
            exp_y = one << i;
            tick();             // accept edge
            for (int k = 1; k <= 4; k++) begin
                n_checks++;
                if ({Y, ready, done} !== {exp_y, 1'b0, 1'b0}) begin
                    n_fail++;
                    $display("FAIL sweep_a%0d_c%0d: Y/ready/done got %b %b %b want %b 0 0", i, k, Y, ready, done, exp_y);
                end
                tick();
            end
            n_checks++;
            if ({Y, ready, done} !== {4'b0000, 1'b0, 1'b1}) begin
                n_fail++;
                $display("FAIL sweep_a%0d_c5: Y/ready/done got %b %b %b want 0000 0 1", i, Y, ready, done);
            end
            tick();
            n_checks++;         // next accept happens on the edge ending this cycle
            if ({Y, ready, done} !== {4'b0000, 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL sweep_a%0d_c6: Y/ready/done got %b %b %b want 0000 1 0", i, Y, ready, done);
            end
        end
        req = 1'b0; V = 1'b0; A = 2'd0;
        tick();
    endtask

    task automatic test_invalid_req();
        logic [7:0] exp_cnt;
        V = 1'b0; req = 1'b1; A = 2'd1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if ({Y, ready, busy} !== {4'b0000, 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL invalid_req_%0d: Y/ready/busy got %b %b %b want 0000 1 0", i, Y, ready, busy);
            end
        end
        req = 1'b0;
        exp_cnt = ERR_EN ? 8'd3 : 8'd0;
        n_checks++;
        if (err_cnt !== exp_cnt) begin
            n_fail++;
            $display("FAIL invalid_err_cnt: got %0d want %0d", err_cnt, exp_cnt);
        end
    endtask

    task automatic test_ignore_during_pulse();
        A = 2'd1; V = 1'b1; req = 1'b1;
        tick();                 // cycle 1
        req = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            if (k == 2) begin
                A = 2'd3; req = 1'b1;
            end else begin
                req = 1'b0;
            end
            n_checks++;
            if ({Y, ready} !== {4'b0010, 1'b0}) begin
                n_fail++;
                $display("FAIL ignore_c%0d: Y/ready got %b %b want 0010 0", k, Y, ready);
            end
            tick();
        end
        req = 1'b0;
        tick();                 // cycle 6
        n_checks++;
        if ({Y, ready, busy} !== {4'b0000, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL ignore_after_gap: Y/ready/busy got %b %b %b want 0000 1 0", Y, ready, busy);
        end
        tick();                 // nothing queued: still idle
        n_checks++;
        if ({Y, ready, busy} !== {4'b0000, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL ignore_not_queued: Y/ready/busy got %b %b %b want 0000 1 0", Y, ready, busy);
        end
        V = 1'b0;
    endtask

    task automatic test_reset_mid_pulse();
        A = 2'd3; V = 1'b1; req = 1'b1;
        tick();                 // cycle 1
        req = 1'b0;
        tick();                 // cycle 2
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({Y, ready, busy, done} !== {4'b0000, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL rst_mid_async: Y/ready/busy/done got %b %b %b %b want 0000 1 0 0", Y, ready, busy, done);
        end
        tick();
        n_checks++;
        if ({Y, done, err_cnt} !== {4'b0000, 1'b0, 8'd0}) begin
            n_fail++;
            $display("FAIL rst_mid_hold: Y/done/err_cnt got %b %b %0d want 0000 0 0", Y, done, err_cnt);
        end
        rst_n = 1'b1;
        A = 2'd1; V = 1'b1; req = 1'b1;
        tick();
        req = 1'b0; V = 1'b0;
        n_checks++;
        if ({Y, done} !== {4'b0010, 1'b0}) begin
            n_fail++;
            $display("FAIL rst_first_accept: Y/done got %b %b want 0010 0", Y, done);
        end
        for (int k = 0; k < 6; k++) tick();
    endtask

    task automatic test_saturate();
        logic [1:0] exp_cnt;
        V = 1'b0; req2 = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            exp_cnt = ERR_EN ? ((i > 3) ? 2'd3 : 2'(i)) : 2'd0;
            n_checks++;
            if ({err_cnt2, Y2, ready2} !== {exp_cnt, 4'b0000, 1'b1}) begin
                n_fail++;
                $display("FAIL saturate_%0d: err_cnt/Y/ready got %0d %b %b want %0d 0000 1", i, err_cnt2, Y2, ready2, exp_cnt);
            end
        end
        req2 = 1'b0;
    endtask

    task automatic test_no_gap();
        A = 2'd0; V = 1'b1; req2 = 1'b1;
        tick();                 // cycle 1
        for (int k = 1; k <= 2; k++) begin
            n_checks++;
            if ({Y2, ready2, done2} !== {4'b0001, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL nogap_c%0d: Y/ready/done got %b %b %b want 0001 0 0", k, Y2, ready2, done2);
            end
            tick();
        end
        n_checks++;             // cycle 3: done and ready together
        if ({Y2, ready2, busy2, done2} !== {4'b0000, 1'b1, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL nogap_c3: Y/ready/busy/done got %b %b %b %b want 0000 1 0 1", Y2, ready2, busy2, done2);
        end
        A = 2'd3;
        tick();                 // accepted on edge 3
        req2 = 1'b0; V = 1'b0;
        n_checks++;
        if ({Y2, ready2, done2} !== {4'b1000, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL nogap_reaccept: Y/ready/done got %b %b %b want 1000 0 0", Y2, ready2, done2);
        end
        for (int k = 0; k < 3; k++) tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_single_pulse();
        test_back_to_back();
        test_invalid_req();
        test_ignore_during_pulse();
        test_reset_mid_pulse();
        test_saturate();
        test_no_gap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
